// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side controller for the synchronous fifo with a 2-entry prefetch buffer
module fifo_reader #(
    parameter int width = 4,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empthy,
    input  logic [width-1:0] fifo_data,
    output logic             read,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [cnt_w-1:0] word_cnt
);

    localparam logic [cnt_w-1:0] cnt_one = {{(cnt_w-1){1'b0}}, 1'b1};

    logic [width-1:0] buf0;
    logic [width-1:0] buf1;
    logic [width-1:0] buf0_nxt;
    logic [width-1:0] buf1_nxt;
    logic [1:0]       buf_count;
    logic             inflight;
    logic             pop;
    logic [1:0]       kept;
    logic [1:0]       occupancy;

    assign out_valid = (buf_count != 2'd0);
    assign out_data  = buf0;

    always_comb begin
        pop       = out_valid && out_ready;
        kept      = buf_count - {1'b0, pop};
        occupancy = kept + {1'b0, inflight};
        read      = !rst && en && !empthy && (occupancy < 2'd2);
    end

    // Shift only when a second word exists, so an emptied buffer keeps showing its last word.
    always_comb begin
        buf0_nxt = buf0;
        buf1_nxt = buf1;
        if (pop && (buf_count == 2'd2)) begin
            buf0_nxt = buf1;
        end
        if (inflight) begin
            if (kept == 2'd0) begin
                buf0_nxt = fifo_data;
            end else begin
                buf1_nxt = fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0      <= '0;
            buf1      <= '0;
            buf_count <= 2'd0;
            inflight  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            buf0      <= buf0_nxt;
            buf1      <= buf1_nxt;
            buf_count <= occupancy;
            inflight  <= read;
            if (pop && (word_cnt != '1)) begin
                word_cnt <= word_cnt + cnt_one;
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader with a behavioural fifo and scoreboard
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       empthy = 1'b1;
    logic [3:0] fifo_data = '0;
    logic       read;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [15:0] word_cnt;

    logic       read_b;
    logic [3:0] out_data_b;
    logic       out_valid_b;
    logic [2:0] word_cnt_b;

    logic       wr_en = 1'b0;
    logic [3:0] wr_data = '0;
    logic [3:0] fq[$];

    int n_cmp = 0;
    int n_err = 0;
    int popped = 0;
    int accepted = 0;
    int prev_hold = 0;
    logic [3:0] prev_data = '0;
    logic [3:0] exp_q[$];

    typedef struct {
        int nwords;
        int mode;
        int exp_cnt;
        int exp_cnt3;
    } scen_t;
    scen_t scen[5];

    always #5 clk = ~clk;

    fifo_reader #(.width(4), .cnt_w(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .empthy(empthy), .fifo_data(fifo_data),
        .read(read), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .word_cnt(word_cnt)
    );

    fifo_reader #(.width(4), .cnt_w(3)) u_sat (
        .clk(clk), .rst(rst), .en(en), .empthy(empthy), .fifo_data(fifo_data),
        .read(read_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .word_cnt(word_cnt_b)
    );

    // Registered-output fifo: a pop at edge N presents the word during cycle N+1.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_data <= '0;
            empthy    <= 1'b1;
        end else begin
            if (read && fq.size() != 0) fifo_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            empthy <= (fq.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic monitor();
        if (rst) begin
            check("read_in_rst", {31'd0, read}, 0);
        end else begin
            check("word_cnt", {16'd0, word_cnt}, (accepted > 65535) ? 65535 : accepted);
            check("word_cnt_sat", {29'd0, word_cnt_b}, (accepted > 7) ? 7 : accepted);
            check("read_match", {31'd0, read_b}, {31'd0, read});
            if (read) begin
                check("read_on_empty", {31'd0, empthy}, 0);
                popped++;
            end
            if (prev_hold != 0) begin
                check("hold_valid", {31'd0, out_valid}, 1);
                check("hold_data", {28'd0, out_data}, {28'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_word", 1, 0);
                else check("stream_data", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
                accepted++;
            end
            check("occupancy_le_2", {31'd0, (popped - accepted) <= 2}, 1);
            prev_hold = (out_valid && !out_ready) ? 1 : 0;
            prev_data = out_data;
        end
    endtask

    // Inputs change only at posedge+1, so negedge values are what the next edge samples.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        out_ready = 1'b0;
        #1;
        check("read_rst_comb", {31'd0, read}, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        popped = 0;
        accepted = 0;
        prev_hold = 0;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_cnt", {16'd0, word_cnt}, 0);
        check("rst_data", {28'd0, out_data}, 0);
    endtask

    task automatic push_word(input logic [3:0] w);
        wr_en = 1'b1;
        wr_data = w;
        exp_q.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic preload(input int first, input int n);
        en = 1'b0;
        do_reset();
        for (int i = 0; i < n; i++) push_word(4'(first + i));
        tick();
        tick();
    endtask

    initial begin
        int cyc;
        int pushed;
        scen[0] = '{nwords: 5,  mode: 0, exp_cnt: 5,  exp_cnt3: 5};
        scen[1] = '{nwords: 8,  mode: 1, exp_cnt: 8,  exp_cnt3: 7};
        scen[2] = '{nwords: 10, mode: 0, exp_cnt: 10, exp_cnt3: 7};
        scen[3] = '{nwords: 3,  mode: 2, exp_cnt: 3,  exp_cnt3: 3};
        scen[4] = '{nwords: 1,  mode: 1, exp_cnt: 1,  exp_cnt3: 1};

        do_reset();

        // Latency and full-rate streaming of 2..6
        preload(2, 5);
        en = 1'b1;
        out_ready = 1'b1;
        #1;
        check("first_read", {31'd0, read}, 1);
        tick();
        check("lat_valid_n", {31'd0, out_valid}, 0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            check("lat_valid", {31'd0, out_valid}, 1);
            check("lat_data", {28'd0, out_data}, k);
        end
        tick();
        check("drained_valid", {31'd0, out_valid}, 0);
        check("drained_read", {31'd0, read}, 0);
        check("cnt_after_5", {16'd0, word_cnt}, 5);

        // Backpressure: exactly two pops, head word held
        preload(2, 5);
        en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("bp_pops", popped, 2);
        check("bp_valid", {31'd0, out_valid}, 1);
        check("bp_data", {28'd0, out_data}, 2);
        check("bp_read", {31'd0, read}, 0);
        out_ready = 1'b1;
        #1;
        check("bp_resume_read", {31'd0, read}, 1);
        cyc = 0;
        while (accepted < 5 && cyc < 20) begin tick(); cyc++; end
        check("bp_delivered", accepted, 5);
        check("bp_cycles", cyc, 5);
        check("bp_cnt", {16'd0, word_cnt}, 5);

        // en dropped after the first read
        preload(10, 4);
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("en_pops", popped, 1);
        check("en_delivered", accepted, 1);
        check("en_read", {31'd0, read}, 0);
        en = 1'b1;
        cyc = 0;
        while (accepted < 4 && cyc < 20) begin tick(); cyc++; end
        check("en_rest", accepted, 4);
        check("en_cnt", {16'd0, word_cnt}, 4);

        // Reset mid-stream: nothing stale may surface afterwards
        preload(1, 6);
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_valid", {31'd0, out_valid}, 0);
            check("post_rst_read", {31'd0, read}, 0);
        end

        // Table of streaming scenarios, words written while streaming
        for (int s = 0; s < 5; s++) begin
            en = 1'b0;
            do_reset();
            en = 1'b1;
            pushed = 0;
            cyc = 0;
            while (accepted < scen[s].nwords && cyc < 400) begin
                if (pushed < scen[s].nwords) begin
                    wr_en = 1'b1;
                    wr_data = 4'($urandom_range(0, 15));
                    exp_q.push_back(wr_data);
                    pushed++;
                end else begin
                    wr_en = 1'b0;
                end
                case (scen[s].mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ((cyc % 2) == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                tick();
                cyc++;
            end
            wr_en = 1'b0;
            out_ready = 1'b0;
            check("scen_delivered", accepted, scen[s].nwords);
            check("scen_cnt", {16'd0, word_cnt}, scen[s].exp_cnt);
            check("scen_cnt3", {29'd0, word_cnt_b}, scen[s].exp_cnt3);
        end

        // Random en / out_ready / write traffic
        en = 1'b0;
        do_reset();
        pushed = 0;
        cyc = 0;
        while ((pushed < 40 || accepted < 40) && cyc < 2000) begin
            if (pushed < 40 && $urandom_range(0, 1) == 1) begin
                wr_en = 1'b1;
                wr_data = 4'($urandom_range(0, 15));
                exp_q.push_back(wr_data);
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
            en = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        check("rand_delivered", accepted, 40);
        check("rand_cnt", {16'd0, word_cnt}, 40);
        check("rand_cnt3", {29'd0, word_cnt_b}, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
